// File: rtl/buffer_fill_unit_pkg.sv
// buffer_fill_unit_pkg: shared FSM encoding, sizes and buffer-select constants
package buffer_fill_unit_pkg;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam logic BUF_A = 1'b0;
  localparam logic BUF_B = 1'b1;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;
  function automatic logic [6:0] clamp_count(input logic [6:0] c);
    return (c > 7'd64) ? 7'd64 : c;
  endfunction
endpackage

// File: rtl/buffer_fill_unit_buffer_bank.sv
// buffer_bank: 64x32 store with one synchronous write, one combinational read and synchronous clear
module buffer_bank
  import buffer_fill_unit_pkg::*;
#(
  parameter int WORDS = DEPTH
) (
  input  logic          clk_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [WORDS];
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/buffer_fill_unit.sv
// buffer_fill_unit: streams a counted burst of words into one of two read-anywhere buffers
module buffer_fill_unit #(
  parameter int p_num = 0,
  parameter int DEPTH = buffer_fill_unit_pkg::DEPTH
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        fill_start,
  input  logic        fill_sel,
  input  logic [6:0]  fill_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        buf_a_valid,
  output logic        buf_b_valid,
  input  logic [5:0]  buf_val_1_addr,
  output logic [31:0] buf_val_1_select,
  input  logic [5:0]  buf_val_2_addr,
  output logic [31:0] buf_val_2_select
);
  import buffer_fill_unit_pkg::*;
  if (DEPTH != 64 || p_num < 0) begin : g_cfg_err
    $error("buffer_fill_unit: DEPTH must be 64 and p_num non-negative");
  end
  state_e state_q, state_d;
  logic sel_q, sel_d;
  logic [6:0] cnt_q, cnt_d;
  logic [5:0] ptr_q, ptr_d;
  logic a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [6:0] req_cnt;
  logic start, beat, last, fin;
  assign req_cnt = clamp_count(fill_count);
  assign start = (state_q == IDLE) && fill_start;
  assign beat = (state_q == FILL) && in_valid;
  assign last = {1'b0, ptr_q} == cnt_q - 7'd1;
  assign fin = (state_q == DONE) && (cnt_q != 7'd0);
  always_comb begin
    state_d = start ? ((req_cnt == 7'd0) ? DONE : FILL) :
              (beat && last) ? DONE :
              (state_q == DONE) ? IDLE : state_q;
    sel_d = start ? fill_sel : sel_q;
    cnt_d = start ? req_cnt : cnt_q;
    ptr_d = start ? 6'd0 : beat ? ptr_q + 6'd1 : ptr_q;
    a_valid_d = (start && fill_sel == BUF_A) ? 1'b0 : (fin && sel_q == BUF_A) ? 1'b1 : a_valid_q;
    b_valid_d = (start && fill_sel == BUF_B) ? 1'b0 : (fin && sel_q == BUF_B) ? 1'b1 : b_valid_q;
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      sel_q <= BUF_A;
      cnt_q <= '0;
      ptr_q <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
    end
  end
  buffer_bank #(.WORDS(DEPTH)) u_bank_a (
    .clk_i(Clk), .clr_i(!Rst), .we_i(beat && sel_q == BUF_A), .waddr_i(ptr_q),
    .wdata_i(in_data), .raddr_i(buf_val_1_addr), .rdata_o(buf_val_1_select)
  );
  buffer_bank #(.WORDS(DEPTH)) u_bank_b (
    .clk_i(Clk), .clr_i(!Rst), .we_i(beat && sel_q == BUF_B), .waddr_i(ptr_q),
    .wdata_i(in_data), .raddr_i(buf_val_2_addr), .rdata_o(buf_val_2_select)
  );
  assign in_ready = state_q == FILL;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign buf_a_valid = a_valid_q;
  assign buf_b_valid = b_valid_q;
endmodule

// File: tb/tb_buffer_fill_unit.sv
// tb_buffer_fill_unit: directed stimulus with a queue-based scoreboard for buffer_fill_unit
module tb_buffer_fill_unit;
  logic Clk = 1'b0;
  logic Rst, fill_start, fill_sel, in_valid;
  logic [6:0] fill_count;
  logic [31:0] in_data, buf_val_1_select, buf_val_2_select;
  logic in_ready, busy, done, buf_a_valid, buf_b_valid;
  logic [5:0] buf_val_1_addr, buf_val_2_addr;
  typedef struct {
    int kind;
    logic [31:0] exp;
    string name;
  } exp_t;
  exp_t exq[$];
  int done_q[$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  buffer_fill_unit #(.p_num(0), .DEPTH(64)) dut (
    .Clk(Clk), .Rst(Rst), .fill_start(fill_start), .fill_sel(fill_sel),
    .fill_count(fill_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .busy(busy), .done(done),
    .buf_a_valid(buf_a_valid), .buf_b_valid(buf_b_valid),
    .buf_val_1_addr(buf_val_1_addr), .buf_val_1_select(buf_val_1_select),
    .buf_val_2_addr(buf_val_2_addr), .buf_val_2_select(buf_val_2_select)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  function automatic logic [31:0] act_of(int k);
    case (k)
      0: return buf_val_1_select;
      1: return buf_val_2_select;
      2: return {31'b0, buf_a_valid};
      3: return {31'b0, buf_b_valid};
      4: return {31'b0, in_ready};
      default: return {31'b0, busy};
    endcase
  endfunction
  always @(negedge Clk) begin
    exp_t e;
    int d;
    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: done=1 in cycle %0d, required no done", cyc + 1);
      end else begin
        d = done_q.pop_front();
        if (cyc + 1 != d) begin
          fails++;
          $display("FAIL done_cycle: done in cycle %0d, required cycle %0d", cyc + 1, d);
        end
      end
    end
    while (exq.size() > 0) begin
      e = exq.pop_front();
      checks++;
      if (act_of(e.kind) !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h, required %h", e.name, act_of(e.kind), e.exp);
      end
    end
  end
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic expect_v(int k, logic [31:0] v, string n);
    exq.push_back('{k, v, n});
  endtask
  task automatic rd(logic [5:0] a1, logic [31:0] e1, logic [5:0] a2, logic [31:0] e2, string n);
    buf_val_1_addr = a1;
    buf_val_2_addr = a2;
    expect_v(0, e1, {n, "_a"});
    expect_v(1, e2, {n, "_b"});
    step();
  endtask
  task automatic flags(logic a, logic b, string n);
    expect_v(2, {31'b0, a}, {n, "_a_valid"});
    expect_v(3, {31'b0, b}, {n, "_b_valid"});
  endtask
  task automatic start_fill(logic s, logic [6:0] c);
    fill_start = 1'b1;
    fill_sel = s;
    fill_count = c;
    step();
    fill_start = 1'b0;
  endtask
  task automatic beat(logic [31:0] d);
    in_valid = 1'b1;
    in_data = d;
    step();
    in_valid = 1'b0;
  endtask
  initial begin
    logic [31:0] t2 [4];
    t2 = '{32'h11, 32'h22, 32'h33, 32'h44};
    Rst = 1'b0; fill_start = 1'b0; fill_sel = 1'b0; fill_count = '0;
    in_valid = 1'b0; in_data = '0; buf_val_1_addr = '0; buf_val_2_addr = '0;
    step();
    step();
    expect_v(4, 0, "rst_in_ready");
    expect_v(5, 0, "rst_busy");
    flags(0, 0, "rst");
    rd(0, 0, 0, 0, "rst_addr0");
    rd(63, 0, 63, 0, "rst_addr63");
    Rst = 1'b1;
    step();
    start_fill(0, 4);
    expect_v(4, 1, "fill_in_ready");
    expect_v(5, 1, "fill_busy");
    for (int i = 0; i < 4; i++) beat(t2[i]);
    done_q.push_back(cyc + 1);
    expect_v(5, 1, "done_busy");
    expect_v(4, 0, "done_in_ready");
    step();
    expect_v(5, 0, "idle_busy");
    flags(1, 0, "t2");
    rd(0, 32'h11, 0, 0, "t2_w0");
    rd(3, 32'h44, 3, 0, "t2_w3");
    start_fill(1, 64);
    for (int i = 0; i < 128; i++) begin
      in_valid = (i % 2 == 0);
      in_data = in_valid ? 32'hB000_0000 + i / 2 : 32'hDEAD_0000 + i;
      step();
      if (i == 0) done_q.push_back(cyc + 127);
    end
    in_valid = 1'b0;
    step();
    flags(1, 1, "t3");
    rd(0, 32'h11, 0, 32'hB000_0000, "t3_w0");
    rd(1, 32'h22, 1, 32'hB000_0001, "t3_w1");
    rd(2, 32'h33, 63, 32'hB000_003F, "t3_w63");
    start_fill(1, 3);
    in_valid = 1'b1; in_data = 32'hC1;
    fill_start = 1'b1; fill_sel = 1'b0; fill_count = 7'd2;
    step();
    fill_start = 1'b0;
    beat(32'hC2);
    beat(32'hC3);
    done_q.push_back(cyc + 1);
    step();
    flags(1, 1, "t4");
    rd(0, 32'h11, 0, 32'hC1, "t4_w0");
    rd(1, 32'h22, 2, 32'hC3, "t4_w2");
    rd(2, 32'h33, 3, 32'hB000_0003, "t4_w3");
    start_fill(0, 0);
    done_q.push_back(cyc + 1);
    step();
    flags(0, 1, "t5");
    rd(0, 32'h11, 0, 32'hC1, "t5_nowrite");
    start_fill(1, 5);
    beat(32'hD0);
    beat(32'hD1);
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    expect_v(4, 0, "abort_in_ready");
    expect_v(5, 0, "abort_busy");
    flags(0, 0, "abort");
    rd(0, 0, 0, 0, "abort_w0");
    rd(1, 0, 1, 0, "abort_w1");
    for (int i = 0; i < 4; i++) step();
    start_fill(0, 100);
    buf_val_1_addr = 6'd0;
    expect_v(0, 0, "same_edge_old");
    beat(32'hE000_0000);
    expect_v(0, 32'hE000_0000, "same_edge_new");
    for (int i = 1; i < 64; i++) beat(32'hE000_0000 + i);
    done_q.push_back(cyc + 1);
    step();
    expect_v(4, 0, "clamp_in_ready");
    flags(1, 0, "clamp");
    rd(63, 32'hE000_003F, 0, 0, "clamp_w63");
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (done_q.size() != 0) begin
      fails++;
      $display("FAIL done_missing: %0d done pulses outstanding, required 0", done_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
